// File: rtl/ring_out_arbiter_if.sv
// Link-side and requester-side signals of one ring output arbiter.
// Grant counters exist only when ARB_STATS_EN is defined.
interface ring_out_arbiter_if #(
    parameter int DW = 64
`ifdef ARB_STATS_EN
    , parameter int CNT_W = 16
`endif
);
    logic          polarity;
    logic          cw_req;
    logic [DW-1:0] cw_di;
    logic          cw_gnt;
    logic          ccw_req;
    logic [DW-1:0] ccw_di;
    logic          ccw_gnt;
    logic          pe_req;
    logic [DW-1:0] pe_di;
    logic          pe_gnt;
    logic          so;
    logic          ro;
    logic [DW-1:0] dout;
`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] gnt_cnt_cw;
    logic [CNT_W-1:0] gnt_cnt_ccw;
    logic [CNT_W-1:0] gnt_cnt_pe;
`endif

    // Requesters and downstream link side
    modport master (
        output polarity, cw_req, cw_di, ccw_req, ccw_di, pe_req, pe_di, ro,
        input  cw_gnt, ccw_gnt, pe_gnt, so, dout
`ifdef ARB_STATS_EN
        , input gnt_cnt_cw, gnt_cnt_ccw, gnt_cnt_pe
`endif
    );

    // Arbiter side
    modport slave (
        input  polarity, cw_req, cw_di, ccw_req, ccw_di, pe_req, pe_di, ro,
        output cw_gnt, ccw_gnt, pe_gnt, so, dout
`ifdef ARB_STATS_EN
        , output gnt_cnt_cw, gnt_cnt_ccw, gnt_cnt_pe
`endif
    );
endinterface

// File: rtl/ring_out_arbiter.sv
// Ring router output-link arbiter: per-VC round-robin among cw/ccw/pe, VCs interleaved
// by polarity. Optional saturating grant counters enabled by ARB_STATS_EN.
module ring_out_arbiter #(
    parameter int DW     = 64,
    parameter int VC_BIT = 63
`ifdef ARB_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input logic clk,
    input logic reset,
    ring_out_arbiter_if.slave bus
);
    logic                 p, q;
    logic [2:0]           req, elig, gnt;
    logic [2:0][DW-1:0]   di;
    logic [1:0]           valid;
    logic [1:0][DW-1:0]   obuf;
    logic [1:0][1:0]      ptr;
    logic                 any;
    logic [1:0]           win, nxt;

    function automatic logic [1:0] wrap3(input logic [2:0] x);
        return (x >= 3'd3) ? 2'(x - 3'd3) : x[1:0];
    endfunction

    // Link drains the VC named by polarity; arbitration fills the other one.
    assign p   = bus.polarity;
    assign q   = ~bus.polarity;
    assign req = {bus.pe_req, bus.ccw_req, bus.cw_req};
    assign di  = {bus.pe_di, bus.ccw_di, bus.cw_di};

    generate
        for (genvar i = 0; i < 3; i++) begin : g_req
            assign elig[i] = req[i] && (di[i][VC_BIT] == q) && !valid[q] && !reset;
        end
    endgenerate

    always_comb begin
        any = 1'b0;
        win = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!any && elig[wrap3({1'b0, ptr[q]} + 3'(k))]) begin
                any = 1'b1;
                win = wrap3({1'b0, ptr[q]} + 3'(k));
            end
        end
        nxt = wrap3({1'b0, win} + 3'd1);
        gnt = any ? (3'b001 << win) : 3'b000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
            obuf  <= '0;
            ptr   <= '0;
        end else begin
            if (valid[p] && bus.ro) valid[p] <= 1'b0;
            if (any) begin
                obuf[q]  <= di[win];
                valid[q] <= 1'b1;
                ptr[q]   <= nxt;
            end
        end
    end

    assign bus.cw_gnt  = gnt[0];
    assign bus.ccw_gnt = gnt[1];
    assign bus.pe_gnt  = gnt[2];
    assign bus.so      = valid[p];
    assign bus.dout    = valid[p] ? obuf[p] : '0;

`ifdef ARB_STATS_EN
    logic [2:0][CNT_W-1:0] cnt;

    generate
        for (genvar i = 0; i < 3; i++) begin : g_cnt
            always_ff @(posedge clk or posedge reset) begin
                if (reset)                      cnt[i] <= '0;
                else if (gnt[i] && ~&cnt[i])    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    endgenerate

    assign bus.gnt_cnt_cw  = cnt[0];
    assign bus.gnt_cnt_ccw = cnt[1];
    assign bus.gnt_cnt_pe  = cnt[2];
`endif
endmodule

// File: tb/tb_ring_out_arbiter.sv
// Directed table-driven bench for ring_out_arbiter plus hand sequences for reset and stats.
module tb_ring_out_arbiter;
    localparam logic [63:0] V1 = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   passed = 0;

`ifdef ARB_STATS_EN
    ring_out_arbiter_if #(.DW(64), .CNT_W(16)) bus ();
    ring_out_arbiter #(.DW(64), .VC_BIT(63), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
    ring_out_arbiter_if #(.DW(64)) bus ();
    ring_out_arbiter #(.DW(64), .VC_BIT(63)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic        pol;
        logic [2:0]  req;
        logic [63:0] cw, ccw, pe;
        logic        ro;
        logic [2:0]  gnt;
        logic        so;
        logic [63:0] dout;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic pol, input logic [2:0] req, input logic [63:0] cw,
                       input logic [63:0] ccw, input logic [63:0] pe, input logic ro,
                       input logic [2:0] gnt, input logic so, input logic [63:0] dout);
        vec_t v;
        v.pol = pol; v.req = req; v.cw = cw; v.ccw = ccw; v.pe = pe;
        v.ro = ro; v.gnt = gnt; v.so = so; v.dout = dout;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic pol, input logic [2:0] req, input logic [63:0] cw,
                         input logic [63:0] ccw, input logic [63:0] pe, input logic ro);
        bus.polarity = pol;
        bus.cw_req = req[0]; bus.ccw_req = req[1]; bus.pe_req = req[2];
        bus.cw_di = cw; bus.ccw_di = ccw; bus.pe_di = pe;
        bus.ro = ro;
    endtask

    function automatic logic [2:0] gnts();
        return {bus.pe_gnt, bus.ccw_gnt, bus.cw_gnt};
    endfunction

    initial begin
        // basic single grant and latency
        add(1, 3'b001, 64'hA5, 0, 0, 1, 3'b001, 0, 0);
        add(0, 3'b000, 0, 0, 0, 1, 3'b000, 1, 64'hA5);
        add(1, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0);
        add(0, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0);
        // wrong-phase request waits for its phase
        add(0, 3'b100, 0, 0, 64'hE05, 1, 3'b000, 0, 0);
        add(1, 3'b100, 0, 0, 64'hE05, 1, 3'b100, 0, 0);
        add(0, 3'b000, 0, 0, 0, 1, 3'b000, 1, 64'hE05);
        // three-way round robin on VC0 (ptr0 starts at 0)
        add(1, 3'b111, 64'hC1, 64'hD1, 64'hE1, 1, 3'b001, 0, 0);
        add(0, 3'b111, 64'hC2, 64'hD1, 64'hE1, 1, 3'b000, 1, 64'hC1);
        add(1, 3'b111, 64'hC2, 64'hD1, 64'hE1, 1, 3'b010, 0, 0);
        add(0, 3'b111, 64'hC2, 64'hD2, 64'hE1, 1, 3'b000, 1, 64'hD1);
        add(1, 3'b111, 64'hC2, 64'hD2, 64'hE1, 1, 3'b100, 0, 0);
        add(0, 3'b111, 64'hC2, 64'hD2, 64'hE2, 1, 3'b000, 1, 64'hE1);
        add(1, 3'b111, 64'hC2, 64'hD2, 64'hE2, 1, 3'b001, 0, 0);
        add(0, 3'b000, 0, 0, 0, 1, 3'b000, 1, 64'hC2);
        // backpressure on VC0
        add(1, 3'b001, 64'h11, 0, 0, 1, 3'b001, 0, 0);
        add(0, 3'b001, 64'h12, 0, 0, 0, 3'b000, 1, 64'h11);
        add(1, 3'b001, 64'h12, 0, 0, 0, 3'b000, 0, 0);
        add(0, 3'b001, 64'h12, 0, 0, 0, 3'b000, 1, 64'h11);
        add(1, 3'b001, 64'h12, 0, 0, 0, 3'b000, 0, 0);
        add(0, 3'b001, 64'h12, 0, 0, 1, 3'b000, 1, 64'h11);
        add(1, 3'b001, 64'h12, 0, 0, 1, 3'b001, 0, 0);
        add(0, 3'b000, 0, 0, 0, 1, 3'b000, 1, 64'h12);
        // mixed VCs: cw on VC1, ccw on VC0
        add(1, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0);
        add(0, 3'b011, V1 | 64'h21, 64'h31, 0, 1, 3'b001, 0, 0);
        add(1, 3'b011, V1 | 64'h22, 64'h31, 0, 1, 3'b010, 1, V1 | 64'h21);
        add(0, 3'b011, V1 | 64'h22, 64'h32, 0, 1, 3'b001, 1, 64'h31);
        add(1, 3'b010, 0, 64'h32, 0, 1, 3'b010, 1, V1 | 64'h22);
        add(0, 3'b000, 0, 0, 0, 1, 3'b000, 1, 64'h32);
        add(1, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0);

        // reset state with an otherwise-eligible request present
        reset = 1'b1;
        drive(0, 3'b001, V1 | 64'h5, 0, 0, 1);
        #2;
        chk("reset so", 64'(bus.so), 0);
        chk("reset dout", bus.dout, 0);
        chk("reset gnt", 64'(gnts()), 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].pol, vq[i].req, vq[i].cw, vq[i].ccw, vq[i].pe, vq[i].ro);
            @(negedge clk);
            chk($sformatf("v%0d gnt", i), 64'(gnts()), 64'(vq[i].gnt));
            chk($sformatf("v%0d so", i), 64'(bus.so), 64'(vq[i].so));
            chk($sformatf("v%0d dout", i), bus.dout, vq[i].dout);
            @(posedge clk); #1;
        end

        // reset mid-stream with buf[0] valid; ptr0 is 1 before reset
        drive(1, 3'b001, 64'h77, 0, 0, 1);
        @(negedge clk);
        chk("pre-reset gnt", 64'(gnts()), 64'b001);
        @(posedge clk); #1;
        drive(0, 3'b001, V1 | 64'h78, 0, 0, 0);
        @(negedge clk);
        chk("pre-reset so", 64'(bus.so), 1);
        chk("pre-reset dout", bus.dout, 64'h77);
        #1 reset = 1'b1;
        #1;
        chk("mid reset so", 64'(bus.so), 0);
        chk("mid reset dout", bus.dout, 0);
        chk("mid reset gnt", 64'(gnts()), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // after release: round robin restarts at cw; four grants cw, ccw, pe, cw
        for (int g = 0; g < 4; g++) begin
            logic [2:0] eg;
            eg = (g == 1) ? 3'b010 : (g == 2) ? 3'b100 : 3'b001;
            drive(1, 3'b111, 64'h100 + 64'(g), 64'h200 + 64'(g), 64'h300 + 64'(g), 1);
            @(negedge clk);
            chk($sformatf("post-reset grant %0d", g), 64'(gnts()), 64'(eg));
            @(posedge clk); #1;
            drive(0, 3'b111, 64'h100 + 64'(g), 64'h200 + 64'(g), 64'h300 + 64'(g), 1);
            @(negedge clk);
            chk($sformatf("post-reset idle %0d", g), 64'(gnts()), 0);
            chk($sformatf("post-reset so %0d", g), 64'(bus.so), 1);
            @(posedge clk); #1;
        end
`ifdef ARB_STATS_EN
        chk("gnt_cnt_cw", 64'(bus.gnt_cnt_cw), 2);
        chk("gnt_cnt_ccw", 64'(bus.gnt_cnt_ccw), 1);
        chk("gnt_cnt_pe", 64'(bus.gnt_cnt_pe), 1);
`endif
        drive(1, 3'b000, 0, 0, 0, 1);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
